// File: rtl/karatsuba_pkg.sv
// Shared constants and tag types for the karatsuba multiplier arbiter.
// The requester ID width is derived from NUM_REQ here, so top-level overrides of NUM_REQ must match.
package karatsuba_pkg;

    localparam int WIDTH   = 128;
    localparam int NUM_REQ = 2;
    localparam int MUL_LAT = 4;
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above the pointer wins, wrapping to the bottom.
// The pointer moves past the winner only on a cycle where the grant is actually taken.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] at_or_above;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick_from;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign at_or_above[gi] = (ptr_reg <= ID_W'(gi));
            assign grant[gi]       = grant_valid && (int'(grant_idx) == gi);
        end
    endgenerate

    assign masked      = req & at_or_above;
    assign pick_from   = (|masked) ? masked : req;
    assign grant_valid = |req;

    // Lowest set bit of the candidate set; scanning downward leaves the lowest one last.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_from[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && grant_valid) begin
            ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/karatsuba_arbiter.sv
// Shares one fixed-latency pipelined multiplier between NUM_REQ requesters.
// A tag pipe running in lockstep with the multiplier routes each result back to its issuer.
module karatsuba_arbiter #(
    parameter int WIDTH   = karatsuba_pkg::WIDTH,
    parameter int NUM_REQ = karatsuba_pkg::NUM_REQ,
    parameter int MUL_LAT = karatsuba_pkg::MUL_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     mul_en,
    output logic                     mul_valid_i,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_valid_o,
    input  logic [2*WIDTH-1:0]       mul_result,
    output logic                     busy,
    output logic                     tag_err
);

    import karatsuba_pkg::*;

    tag_t               tag_pipe_reg [MUL_LAT];
    tag_t               tag_out;
    logic [MUL_LAT-1:0] pipe_vld;
    logic [NUM_REQ-1:0] arb_grant;
    req_id_t            grant_idx;
    logic               grant_valid;
    logic               stall;
    logic               issue;
    logic               rsp_hit;
    logic               tag_err_reg;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .advance     (issue),
        .grant       (arb_grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign tag_out = tag_pipe_reg[MUL_LAT-1];

    // A held result whose owner is not ready freezes the multiplier and the tag pipe together.
    assign stall  = mul_valid_o & ~rsp_ready[tag_out.id];
    assign mul_en = ~stall;

    // Gating with rst_n keeps the handshake outputs quiet while reset is held.
    assign issue       = rst_n & mul_en & grant_valid;
    assign req_ready   = issue ? arb_grant : '0;
    assign mul_valid_i = issue;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign mul_a = issue ? sel_a : '0;
    assign mul_b = issue ? sel_b : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_pipe_reg[i] <= '0;
            end
        end else if (mul_en) begin
            tag_pipe_reg[0] <= '{vld: issue, id: grant_idx};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_vld
            assign pipe_vld[gi] = tag_pipe_reg[gi].vld;
        end
    endgenerate

    assign rsp_hit = mul_valid_o & tag_out.vld;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = rsp_hit && (int'(tag_out.id) == gi);
        end
    endgenerate

    assign rsp_result = rsp_hit ? mul_result : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_err_reg <= 1'b0;
        end else if (mul_valid_o != tag_out.vld) begin
            tag_err_reg <= 1'b1;
        end
    end

    assign tag_err = tag_err_reg;
    assign busy    = (|pipe_vld) | mul_valid_o;

endmodule

// File: tb/tb_karatsuba_arbiter.sv
// Self-checking bench: behavioural multiplier, issue-order scoreboard, vector table and corner sequences.
module tb_karatsuba_arbiter;

    localparam int W   = 128;
    localparam int N   = 2;
    localparam int LAT = 4;
    localparam int PW  = 2 * W;

    typedef struct {
        int            lane;
        logic [PW-1:0] prod;
    } exp_t;

    typedef struct {
        int            lane;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] prod;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '1;
    logic [PW-1:0]  rsp_result;
    logic           mul_en;
    logic           mul_valid_i;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_valid_o;
    logic [PW-1:0]  mul_result;
    logic           busy;
    logic           tag_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    karatsuba_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N),
        .MUL_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .mul_en      (mul_en),
        .mul_valid_i (mul_valid_i),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_valid_o (mul_valid_o),
        .mul_result  (mul_result),
        .busy        (busy),
        .tag_err     (tag_err)
    );

    // Behavioural multiplier: LAT en-qualified stages, holds when mul_en is low.
    logic          mv [LAT];
    logic [PW-1:0] mr [LAT];
    logic          spur = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                mv[i] <= 1'b0;
                mr[i] <= '0;
            end
        end else if (mul_en) begin
            mv[0] <= mul_valid_i;
            mr[0] <= PW'(mul_a) * PW'(mul_b);
            for (int i = 1; i < LAT; i++) begin
                mv[i] <= mv[i-1];
                mr[i] <= mr[i-1];
            end
        end
    end

    assign mul_valid_o = mv[LAT-1] | spur;
    assign mul_result  = mr[LAT-1];

    function automatic void chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    // Scoreboard: expected results in global issue order.
    exp_t exp_q[$];
    int   rsp_cyc_q[$];
    int   model_ptr = 0;
    bit   exp_tag_err = 1'b0;
    int   cyc = 0;
    int   delivered [N];

    initial begin
        for (int i = 0; i < N; i++) delivered[i] = 0;
    end

    always @(negedge clk) begin : monitor
        logic          real_v;
        logic          exp_en;
        logic [N-1:0]  exp_rv;
        logic [N-1:0]  exp_ready;
        logic [PW-1:0] exp_res;
        int            g;
        int            l;
        exp_t          e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            model_ptr   = 0;
            exp_tag_err = 1'b0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_mul_valid_i", mul_valid_i, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tag_err", tag_err, 0);
        end else begin
            real_v  = mv[LAT-1];
            exp_rv  = '0;
            exp_res = '0;
            exp_en  = 1'b1;
            g       = 0;
            chk("busy", busy, (exp_q.size() != 0) || mul_valid_o);
            chk("tag_err", tag_err, exp_tag_err);
            if (real_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got result with empty scoreboard (t=%0t)", $time);
                end else begin
                    exp_rv[exp_q[0].lane] = 1'b1;
                    exp_res = exp_q[0].prod;
                    exp_en  = rsp_ready[exp_q[0].lane];
                end
            end
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_result", rsp_result, exp_res);
            if (!(spur && !real_v)) chk("mul_en", mul_en, exp_en);
            if (real_v && exp_en && exp_q.size() != 0) begin
                delivered[exp_q[0].lane]++;
                rsp_cyc_q.push_back(cyc);
                void'(exp_q.pop_front());
            end
            exp_ready = '0;
            if (exp_en) begin
                for (int k = 0; k < N; k++) begin
                    l = (model_ptr + k) % N;
                    if (exp_ready == 0 && req_valid[l]) begin
                        exp_ready[l] = 1'b1;
                        g = l;
                    end
                end
            end
            chk("req_ready", req_ready, exp_ready);
            chk("mul_valid_i", mul_valid_i, |exp_ready);
            if (exp_ready != 0) begin
                chk("mul_a", mul_a, req_a[g*W +: W]);
                chk("mul_b", mul_b, req_b[g*W +: W]);
                e.lane = g;
                e.prod = PW'(req_a[g*W +: W]) * PW'(req_b[g*W +: W]);
                exp_q.push_back(e);
                model_ptr = (g + 1) % N;
            end else begin
                chk("mul_a_idle", mul_a, 0);
                chk("mul_b_idle", mul_b, 0);
            end
            if (spur && !real_v) exp_tag_err = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        spur      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[lane*W +: W] = a;
        req_b[lane*W +: W] = b;
    endtask

    function automatic logic [W-1:0] rand_op();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain(input string name);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        tick();
    endtask

    task automatic issue_one(input int lane, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [PW-1:0] prod, input string name);
        logic [N-1:0] oh;
        int           lat;
        bit           ok;
        oh = '0;
        oh[lane] = 1'b1;
        set_op(lane, a, b);
        req_valid = oh;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready == oh) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_accept"}, ok, 1);
        tick();
        req_valid = '0;
        lat = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid != 0) break;
        end
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_lane"}, rsp_valid, oh);
        chk({name, "_result"}, rsp_result, prod);
        tick();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        vec_t          vecs [6];
        logic [N-1:0]  got;
        logic [N-1:0]  pend;
        logic [PW-1:0] saved;
        int            n;
        int            base;
        int            d1;
        int            seen;
        bit            found;

        vecs[0] = '{0, W'(3), W'(5), PW'(15)};
        vecs[1] = '{1, W'(7), W'(9), PW'(63)};
        vecs[2] = '{0, W'(0), W'(123), PW'(0)};
        vecs[3] = '{1, {W{1'b1}}, W'(1), PW'({W{1'b1}})};
        vecs[4] = '{0, {W{1'b1}}, {W{1'b1}}, {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1}};
        vecs[5] = '{1, {1'b1, {(W-1){1'b0}}}, W'(2), {{(W-1){1'b0}}, 1'b1, {W{1'b0}}}};

        do_reset();

        // Single operations from the table, one at a time.
        for (int i = 0; i < 6; i++) begin
            issue_one(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].prod, "vec");
        end

        // Contention: both lanes valid in the same cycle.
        do_reset();
        set_op(0, W'(2), W'(3));
        set_op(1, W'(3), W'(5));
        req_valid = 2'b11;
        @(negedge clk);
        chk("cont_grant0", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("cont_grant1", req_ready, 2'b10);
        tick();
        req_valid = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid != 0) break;
        end
        chk("cont_rsp0_lane", rsp_valid, 2'b01);
        chk("cont_rsp0_val", rsp_result, 6);
        @(negedge clk);
        chk("cont_rsp1_lane", rsp_valid, 2'b10);
        chk("cont_rsp1_val", rsp_result, 15);
        tick();

        // Streaming: 20 issues with alternating grants, one result per cycle.
        do_reset();
        base = rsp_cyc_q.size();
        set_op(0, rand_op(), rand_op());
        set_op(1, rand_op(), rand_op());
        req_valid = 2'b11;
        n = 0;
        for (int t = 0; t < 60 && n < 20; t++) begin
            @(negedge clk);
            got = req_ready;
            chk("stream_grant", got, (n % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            if (got != 0) begin
                n++;
                set_op(got[1] ? 1 : 0, rand_op(), rand_op());
            end
            if (n == 20) req_valid = '0;
        end
        drain("stream");
        chk("stream_count", rsp_cyc_q.size() - base, 20);
        if (rsp_cyc_q.size() - base == 20) begin
            chk("stream_spacing", rsp_cyc_q[base+19] - rsp_cyc_q[base], 19);
        end

        // Backpressure: lane1 refuses its result for 5 cycles.
        do_reset();
        rsp_ready = 2'b01;
        d1 = delivered[1];
        set_op(0, rand_op(), rand_op());
        set_op(1, rand_op(), rand_op());
        req_valid = 2'b11;
        found = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                found = 1'b1;
                break;
            end
            got = req_ready;
            tick();
            if (got[1]) req_valid[1] = 1'b0;
            if (got[0]) set_op(0, rand_op(), rand_op());
        end
        chk("bp_reached", found, 1);
        saved = rsp_result;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_mul_en", mul_en, 0);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 2'b10);
            chk("bp_rsp_stable", rsp_result, saved);
            tick();
        end
        rsp_ready = 2'b11;
        req_valid = '0;
        drain("bp");
        chk("bp_lane1_once", delivered[1] - d1, 1);

        // Reset with three ops in flight.
        do_reset();
        set_op(0, rand_op(), rand_op());
        set_op(1, rand_op(), rand_op());
        req_valid = 2'b11;
        n = 0;
        for (int t = 0; t < 20 && n < 3; t++) begin
            @(negedge clk);
            got = req_ready;
            tick();
            if (got != 0) begin
                n++;
                set_op(got[1] ? 1 : 0, rand_op(), rand_op());
            end
            if (n == 3) req_valid = '0;
        end
        chk("midrst_issued", n, 3);
        rst_n = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        seen = 0;
        for (int t = 0; t < LAT + 4; t++) begin
            @(negedge clk);
            if (rsp_valid != 0) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        chk("midrst_idle", busy, 0);
        tick();
        issue_one(0, W'(2), W'(3), PW'(6), "midrst_new");

        // Spurious multiplier valid with an empty tag pipe.
        do_reset();
        spur = 1'b1;
        @(negedge clk);
        chk("tag_no_rsp", rsp_valid, 0);
        tick();
        spur = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tag_err_sticky", tag_err, 1);
            chk("tag_no_rsp_after", rsp_valid, 0);
            tick();
        end
        do_reset();
        @(negedge clk);
        chk("tag_err_cleared", tag_err, 0);
        tick();

        // Random traffic with random response backpressure.
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < N; l++) begin
                if (!pend[l] && $urandom_range(0, 3) != 0) begin
                    pend[l] = 1'b1;
                    if ($urandom_range(0, 1) == 0) set_op(l, rand_op(), rand_op());
                    else set_op(l, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
                end
                rsp_ready[l] = ($urandom_range(0, 3) != 0);
            end
            req_valid = pend;
            @(negedge clk);
            pend = pend & ~req_ready;
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
